// File: rtl/button_conditioner.sv
// button_conditioner: sync, debounce and press/release/short/long classification of one push-button (BUTTON_CONDITIONER_REPEAT_EN adds auto-repeat)
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 12500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic button_in,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(LONG_CYCLES) + 1;
  typedef enum logic [2:0] {IDLE, DEB_PRESS, HELD, LONG_HELD, DEB_RELEASE} state_t;
  state_t state;
  logic [1:0] sync;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  logic long_flag;
  logic s;
  assign s = sync[1];
  // two-flop synchroniser of the press level; resets to the released level
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) sync <= 2'b00;
    else sync <= {sync[0], button_in ^ ACTIVE_LOW};
  // debounce and classification FSM with registered level and pulse outputs
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      deb_cnt <= '0;
      hold_cnt <= '0;
      long_flag <= 1'b0;
      pressed <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse <= 1'b0;
      long_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse <= 1'b0;
      long_pulse <= 1'b0;
      case (state)
        IDLE:
          if (s) begin
            state <= DEB_PRESS;
            deb_cnt <= '0;
          end
        DEB_PRESS:
          if (!s) begin
            state <= IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            state <= HELD;
            deb_cnt <= '0;
            pressed <= 1'b1;
            press_pulse <= 1'b1;
            hold_cnt <= '0;
            long_flag <= 1'b0;
          end else deb_cnt <= deb_cnt + DW'(1);
        HELD: begin
          if (hold_cnt != HW'(LONG_CYCLES)) hold_cnt <= hold_cnt + HW'(1);
          if (hold_cnt == HW'(LONG_CYCLES - 1)) begin
            state <= LONG_HELD;
            long_pulse <= 1'b1;
            long_flag <= 1'b1;
          end else if (!s) begin
            state <= DEB_RELEASE;
            deb_cnt <= '0;
          end
        end
        LONG_HELD:
          if (!s) begin
            state <= DEB_RELEASE;
            deb_cnt <= '0;
          end
        DEB_RELEASE:
          if (s) begin
            state <= long_flag ? LONG_HELD : HELD;
            deb_cnt <= '0;
          end else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
            state <= IDLE;
            deb_cnt <= '0;
            pressed <= 1'b0;
            release_pulse <= 1'b1;
            short_pulse <= !long_flag;
          end else deb_cnt <= deb_cnt + DW'(1);
        default: state <= IDLE;
      endcase
    end
`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES) + 1;
  logic [RW-1:0] rep_cnt;
  // auto-repeat timer: runs while long-held, holds across a release bounce, clears otherwise
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      rep_cnt <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (state == LONG_HELD) begin
        repeat_pulse <= rep_cnt == RW'(REPEAT_CYCLES - 1);
        rep_cnt <= rep_cnt == RW'(REPEAT_CYCLES - 1) ? '0 : rep_cnt + RW'(1);
      end else if (state != DEB_RELEASE) rep_cnt <= '0;
    end
`else
  assign repeat_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of debounce timing, classification and reset behaviour
module tb_button_conditioner;
  logic CLK, rst_n, button_in;
  logic pressed, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse;
  int vecs = 0, errs = 0, cyc = 0;
  int press_n, rel_n, short_n, long_n, rep_n, hi_n, viol = 0, rep_total = 0;
  int press_at, rel_at, short_at, long_at, rep1_at, rep2_at;
  int t0, tr;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8), .ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK), .rst_n(rst_n), .button_in(button_in), .pressed(pressed),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .short_pulse(short_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // event recorder: cyc holds the number of the edge that produced the outputs
  always @(posedge CLK) begin
    #1;
    if (press_pulse) begin press_n++; press_at = cyc; end
    if (release_pulse) begin rel_n++; rel_at = cyc; end
    if (short_pulse) begin short_n++; short_at = cyc; end
    if (long_pulse) begin long_n++; long_at = cyc; end
    if (repeat_pulse) begin
      if (rep_n == 0) rep1_at = cyc;
      else if (rep_n == 1) rep2_at = cyc;
      rep_n++;
      rep_total++;
    end
    if (pressed) hi_n++;
    if (press_pulse && release_pulse) viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clr;
    press_n = 0; rel_n = 0; short_n = 0; long_n = 0; rep_n = 0; hi_n = 0;
    press_at = -1; rel_at = -1; short_at = -1; long_at = -1; rep1_at = -1; rep2_at = -1;
  endtask

  // drive a pin level at a negedge; t is the first edge that samples it
  task automatic drive(input logic v, output int t);
    button_in = v;
    t = cyc + 1;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    button_in = 1'b1;
    tick(3);
    check("reset_outs", {pressed, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse}, 0);
    rst_n = 1'b1;
    tick(3);
    check("no_pulse_reset_exit", press_n + rel_n + short_n + long_n, 0);

    clr();
    drive(1'b0, t0);
    tick(10);
    check("clean_pressed", pressed, 1);
    drive(1'b1, tr);
    tick(12);
    check("clean_press_n", press_n, 1);
    check("clean_press_lat", press_at - t0, 6);
    check("clean_rel_n", rel_n, 1);
    check("clean_rel_lat", rel_at - tr, 6);
    check("clean_short_n", short_n, 1);
    check("clean_short_with_rel", short_at, rel_at);
    check("clean_long_n", long_n, 0);
    check("clean_released", pressed, 0);

    clr();
    for (int i = 0; i < 15; i++) begin
      button_in = i % 2 == 0 ? 1'b0 : 1'b1;
      tick(2);
    end
    button_in = 1'b1;
    tick(12);
    check("bounce_pulses", press_n + rel_n + short_n + long_n, 0);
    check("bounce_pressed_hi", hi_n, 0);

    clr();
    drive(1'b0, t0);
    tick(40);
    drive(1'b1, tr);
    tick(12);
    check("long_press_lat", press_at - t0, 6);
    check("long_n", long_n, 1);
    check("long_after_press", long_at - press_at, 20);
    check("long_rel_n", rel_n, 1);
    check("long_rel_lat", rel_at - tr, 6);
    check("long_short_n", short_n, 0);

    clr();
    drive(1'b0, t0);
    tick(12);
    button_in = 1'b1;
    tick(2);
    button_in = 1'b0;
    tick(30);
    check("glitch_rel_n", rel_n, 0);
    check("glitch_long_n", long_n, 1);
    check("glitch_long_after_press", long_at - press_at, 22);
    drive(1'b1, tr);
    tick(12);
    check("glitch_final_rel_n", rel_n, 1);
    check("glitch_short_n", short_n, 0);

    clr();
    drive(1'b0, t0);
    tick(35);
    check("rst_mid_long_n", long_n, 1);
    check("rst_mid_pressed", pressed, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {pressed, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse}, 0);
    tick(2);
    clr();
    rst_n = 1'b1;
    t0 = cyc + 1;
    tick(10);
    check("rst_repress_n", press_n, 1);
    check("rst_repress_lat", press_at - t0, 6);
    check("rst_exit_rel_n", rel_n, 0);
    drive(1'b1, tr);
    tick(12);
    check("rst_final_rel_n", rel_n, 1);

`ifdef BUTTON_CONDITIONER_REPEAT_EN
    clr();
    drive(1'b0, t0);
    tick(50);
    drive(1'b1, tr);
    tick(12);
    check("rep_long_n", long_n, 1);
    check("rep_first", rep1_at - long_at, 8);
    check("rep_second", rep2_at - long_at, 16);
    check("rep_rel_n", rel_n, 1);
`else
    clr();
    drive(1'b0, t0);
    tick(50);
    drive(1'b1, tr);
    tick(12);
    check("norep_long_n", long_n, 1);
    check("norep_total", rep_total, 0);
`endif
    check("press_release_overlap", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
